// File: rtl/pc_sequencer_pkg.sv
// Shared sizing and FSM encoding for the program-counter sequencer.
package pc_sequencer_pkg;

  localparam int ADDR_W  = 5;
  localparam int TIMEOUT = 15;
  localparam int WAIT_W  = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection: halt > jump > taken branch > sequential, all modulo 2^ADDR_W.
module pc_next_calc #(
  parameter int ADDR_W = pc_sequencer_pkg::ADDR_W
) (
  input  logic              reset,
  input  logic              exec_en,
  input  logic              stall,
  input  logic              halt,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic [ADDR_W-1:0] pc_cur,
  output logic [ADDR_W-1:0] pc_next
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_br;

  // Plain truncating adds give the required wraparound.
  assign pc_inc = pc_cur + ONE;
  assign pc_br  = pc_inc + branch_offset;

  always_comb begin
    pc_next = pc_cur;
    if (reset)
      pc_next = '0;
    else if (exec_en && !stall && !halt) begin
      if (jump)
        pc_next = jump_target;
      else if (branch_taken)
        pc_next = pc_br;
      else
        pc_next = pc_inc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/EXEC/HALT sequencer driving an external PC register, with fetch timeout fault.
module pc_sequencer #(
  parameter int ADDR_W  = pc_sequencer_pkg::ADDR_W,
  parameter int TIMEOUT = pc_sequencer_pkg::TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc_next,
  output logic              pc_write,
  output logic              imem_req,
  output logic              instr_valid,
  output logic [1:0]        state,
  output logic              halted,
  output logic              fault
);

  import pc_sequencer_pkg::*;

  // Last count value before the TIMEOUT-th miss; a miss here ends the fetch.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= FETCH;
      wait_cnt    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (st)
        FETCH: begin
          if (imem_ready) begin
            st          <= EXEC;
            instr_valid <= 1'b1;
            wait_cnt    <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            st     <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        EXEC: begin
          if (!stall) begin
            if (halt) begin
              st     <= HALT;
              halted <= 1'b1;
            end else begin
              st       <= FETCH;
              wait_cnt <= '0;
            end
          end
        end
        HALT:    st <= HALT;
        default: st <= FETCH;
      endcase
    end
  end

  assign state    = st;
  assign imem_req = !reset && (st == FETCH);
  assign pc_write = !reset && (st == EXEC) && !stall && !halt;

  pc_next_calc #(.ADDR_W(ADDR_W)) u_calc (
    .reset         (reset),
    .exec_en       (st == EXEC),
    .stall         (stall),
    .halt          (halt),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next)
  );

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: ADDR_W, default 5, program-counter width in bits.
REQ-002 Parameter: TIMEOUT, default 15, maximum FETCH wait cycles before fault.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc_cur  input  ADDR_W  current value held by the external PC register.
REQ-006 imem_ready  input  1  instruction memory has the word at pc_cur.
REQ-007 stall  input  1  hold the current instruction in EXEC; no PC update.
REQ-008 branch_taken  input  1  branch resolved taken this EXEC cycle.
REQ-009 branch_offset  input  ADDR_W  two's-complement offset relative to pc_cur+1.
REQ-010 jump  input  1  absolute jump this EXEC cycle.
REQ-011 jump_target  input  ADDR_W  absolute jump address.
REQ-012 halt  input  1  current instruction is HALT.
REQ-013 pc_next  output  ADDR_W  value the external PC register loads.
REQ-014 pc_write  output  1  load enable for the external PC register.
REQ-015 imem_req  output  1  fetch request to instruction memory.
REQ-016 instr_valid  output  1  one-cycle pulse: fetched instruction is ready to execute.
REQ-017 state  output  2  encoded FSM state, for debug.
REQ-018 halted  output  1  sequencer is in HALT.
REQ-019 fault  output  1  fetch timeout occurred; sticky until reset.

Function
REQ-020 FSM states SHALL be FETCH, EXEC and HALT; the state encoding is defined in the shared package.
REQ-021 In FETCH: imem_req=1 and pc_write=0; on a sampled imem_ready=1, the next state SHALL be EXEC.
REQ-022 In FETCH: a 4-bit wait counter SHALL increment on each cycle with imem_ready=0 and clear on entry to FETCH.
REQ-023 In FETCH: when the wait counter reaches TIMEOUT with imem_ready still 0, the next state SHALL be HALT with fault=1.
REQ-024 instr_valid SHALL be registered and SHALL be high only during the first cycle of each EXEC visit.
REQ-025 In EXEC with stall=1: remain in EXEC, pc_write=0, pc_next=pc_cur.
REQ-026 In EXEC with stall=0: pc_write=1 and the next state is FETCH, except when halt=1.
REQ-027 In EXEC with stall=0 and halt=1: pc_write=0, the next state is HALT, and fault stays 0.
REQ-028 pc_next priority SHALL be halt (pc_cur) > jump (jump_target) > branch_taken (pc_cur+1+branch_offset) > default (pc_cur+1).
REQ-029 All address arithmetic SHALL be modulo 2^ADDR_W: 31+1 gives 0; pc 2, offset 5'b11101 gives 0.
REQ-030 jump and branch_taken both high in the same cycle: jump SHALL win.
REQ-031 Outside EXEC, pc_next SHALL equal pc_cur and pc_write SHALL be 0.
REQ-032 HALT SHALL be absorbing: halted=1, imem_req=0, pc_write=0 until reset; no input other than reset leaves it.
REQ-033 pc_next and pc_write SHALL be combinational from state and inputs, so the PC updates on the edge that ends the EXEC cycle.

Reset
REQ-034 While reset=1 at a rising edge: state becomes FETCH and the wait counter, instr_valid, halted and fault all become 0.
REQ-035 While reset=1: pc_write=0, imem_req=0 and pc_next=0, so the external PC register also resets to 0.
REQ-036 Reset asserted during any state, including mid-stall or HALT, SHALL take effect at the next edge with no residual state.

Structure
REQ-037 The shared package SHALL hold ADDR_W, TIMEOUT, the state enum typedef and its encoding (FETCH=0, EXEC=1, HALT=2).
REQ-038 Next-PC selection and arithmetic SHALL be isolated in one combinational sub-module, pc_next_calc.
REQ-039 The FSM and wait counter SHALL remain in pc_sequencer.

Verification
REQ-040 Reset, then pc_cur=0 with imem_ready=1 on the second cycle -> EXEC, instr_valid pulses once, pc_write=1, pc_next=1.
REQ-041 EXEC, pc_cur=4, branch_taken=1, offset=5'b11110 -> pc_next=3; with jump=1 and target=20 added -> pc_next=20.
REQ-042 pc_cur=31, no branch or jump -> pc_next=0 (wrap); stall=1 for 3 cycles -> pc_write=0 throughout, instr_valid pulses only once.
REQ-043 imem_ready held at 0 for 15 FETCH cycles -> HALT, fault=1, halted=1; later imem_ready=1 -> no change.
REQ-044 EXEC with halt=1 -> HALT, fault=0, pc stays at pc_cur; reset asserted -> FETCH, pc_next=0, all flags 0.
REQ-045 Reset pulsed mid-stall in EXEC -> FETCH on the next edge, instr_valid=0, pc_write=0.
